// File: rtl/atpg_vector_sequencer.sv
// Cycle-exact ATPG vector sequencer: fetches stimulus from a synchronous ROM, drives a
// combinational DUT, waits a settle interval, then compares and MISR-compacts each response.
module atpg_vector_sequencer #(
  parameter int              IN_W       = 33,
  parameter int              OUT_W      = 25,
  parameter int              NUM_VEC    = 10,
  parameter int              ADDR_W     = 4,
  parameter int              SETTLE_CYC = 1,
  parameter logic [OUT_W-1:0] MISR_POLY = 25'h0000009
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_data,
  input  logic [OUT_W-1:0]  exp_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_idx,
  output logic [OUT_W-1:0]  resp_data,
  output logic [ADDR_W:0]   fail_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [OUT_W-1:0]  signature
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [OUT_W-1:0]  exp_reg;
  logic [CNT_W-1:0]  settle_cnt;
  logic [OUT_W-1:0]  resp_data_reg;
  logic [ADDR_W-1:0] resp_idx_reg;
  logic              capture_fire;
  logic              last_vec;
  logic              mismatch;
  logic              misr_fb;
  logic [OUT_W-1:0]  misr_next;

  // A capture coinciding with abort is discarded entirely.
  assign capture_fire = (state == S_CAPTURE) && !abort;
  assign last_vec     = (idx == ADDR_W'(NUM_VEC - 1));
  assign mismatch     = (dut_out != exp_reg);
  assign misr_fb      = ^(signature & MISR_POLY);
  assign misr_next    = {signature[OUT_W-2:0], misr_fb} ^ dut_out;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign resp_valid = capture_fire;
  // Live response during capture, last captured value otherwise.
  assign resp_data  = capture_fire ? dut_out : resp_data_reg;
  assign resp_idx   = capture_fire ? idx : resp_idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      vec_addr         <= '0;
      dut_in           <= '0;
      exp_reg          <= '0;
      settle_cnt       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      signature        <= '0;
      resp_data_reg    <= '0;
      resp_idx_reg     <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state            <= S_FETCH;
            idx              <= '0;
            vec_addr         <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            signature        <= '0;
          end
        end
        S_FETCH: begin
          state <= S_APPLY;
        end
        S_APPLY: begin
          dut_in     <= vec_data;
          exp_reg    <= exp_data;
          settle_cnt <= CNT_W'(SETTLE_CYC);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - CNT_W'(1);
          if (settle_cnt == CNT_W'(1)) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          resp_data_reg <= dut_out;
          resp_idx_reg  <= idx;
          signature     <= misr_next;
          if (mismatch) begin
            fail_count <= fail_count + (ADDR_W+1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
          end
          if (last_vec) begin
            state <= S_DONE;
          end else begin
            idx      <= idx + ADDR_W'(1);
            vec_addr <= idx + ADDR_W'(1);
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/atpg_vector_sequencer.md
Name: atpg_vector_sequencer

Overview:
- Sequences a stored test-vector set into a combinational ISCAS85 DUT (c1908-sized by default).
- Per vector: fetches the stimulus from a synchronous vector ROM, applies it, waits a settle interval, then captures and compares the DUT response.
- Per run: counts mismatches and compacts all responses into a MISR signature.
- Replaces the delay-based stimulus/capture loop with a synthesizable, cycle-exact controller for on-chip ATPG/BIST runs.

Parameters:
IN_W, 33, DUT primary-input width
OUT_W, 25, DUT primary-output width
NUM_VEC, 10, vectors per run (1..2^ADDR_W)
ADDR_W, 4, vector ROM address width
SETTLE_CYC, 1, cycles DUT inputs are held before capture (>=1)
MISR_POLY, 25'h0000009, MISR feedback tap mask (OUT_W bits)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run; highest priority after rst
vec_addr  out  ADDR_W  ROM read address
vec_data  in  IN_W  ROM stimulus, valid 1 cycle after vec_addr
exp_data  in  OUT_W  ROM expected response, same timing as vec_data
dut_in  out  IN_W  registered stimulus to DUT
dut_out  in  OUT_W  DUT response
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse at normal run completion
resp_valid  out  1  1-cycle pulse per captured vector
resp_idx  out  ADDR_W  index of captured vector
resp_data  out  OUT_W  captured response
fail_count  out  ADDR_W+1  mismatching vectors in current/last run
first_fail_valid  out  1  at least one mismatch seen
first_fail_idx  out  ADDR_W  index of first mismatch
signature  out  OUT_W  MISR value

Behaviour:
- Reset (async): FSM=IDLE. All outputs 0: vec_addr, dut_in, busy, done, resp_*, fail_count, first_fail_*, signature. Settle counter and vector index also 0.
- FSM states:
  - IDLE: on start, go to FETCH. Clear idx, fail_count, first_fail_*, signature; vec_addr<=0.
  - FETCH: 1 cycle (ROM read latency) -> APPLY.
  - APPLY: dut_in<=vec_data; exp_reg<=exp_data; settle counter<=SETTLE_CYC; -> SETTLE.
  - SETTLE: decrement counter each cycle; exactly SETTLE_CYC cycles, then -> CAPTURE.
  - CAPTURE: resp_valid=1, resp_data=dut_out, resp_idx=idx.
    - If dut_out!=exp_reg: fail_count++. If first_fail_valid=0: set first_fail_valid=1, first_fail_idx=idx.
    - Update signature.
    - If idx==NUM_VEC-1 -> DONE; else idx++, vec_addr<=idx+1, -> FETCH.
  - DONE: done=1 for this cycle only -> IDLE.
- Timing: let cycle 0 be the cycle start is high in IDLE.
  - Vector k captures in cycle k*(SETTLE_CYC+3)+SETTLE_CYC+3.
  - done is high in cycle NUM_VEC*(SETTLE_CYC+3)+1.
- MISR: fb = ^(signature & MISR_POLY); signature <= ({signature[OUT_W-2:0],fb}) ^ dut_out. Updated only in CAPTURE.
- Output holding: dut_in holds the last applied vector. Result outputs hold after DONE/abort until the next accepted start.
- start is ignored in every state except IDLE, including DONE. start and abort high together in IDLE: abort wins, start dropped.
- abort in any non-IDLE state -> IDLE next cycle.
  - No done pulse.
  - If abort coincides with CAPTURE, that capture is discarded: no resp_valid, no counter or MISR update.
  - Partial results from earlier vectors are retained.
- rst asserted mid-run: immediate return to reset values; no done pulse.
- fail_count never exceeds NUM_VEC, so no saturation logic is needed.

Test Plan:
- Reset check: assert rst asynchronously mid-SETTLE -> all outputs 0 immediately, busy=0, no done within 50 cycles after release.
- Golden run: NUM_VEC=10, SETTLE_CYC=1, ROM exp_data equals DUT model output -> resp_valid at cycles 4,8,...,40; done at cycle 41; fail_count=0; first_fail_valid=0; signature equals reference MISR model value.
- Injected faults: corrupt exp_data at indices 3 and 7 -> fail_count=2, first_fail_idx=3, first_fail_valid=1; signature unchanged vs. golden run (MISR compacts dut_out, not exp_data).
- Abort on capture edge: abort asserted in vector 5's CAPTURE cycle (cycle 24) -> busy=0 at cycle 25, no done, no resp_valid for vector 5, results reflect vectors 0..4 only.
- Start ignored while busy: start pulses at cycles 2, 20 and in the DONE cycle (41) -> single run with identical timing; restart in IDLE at cycle 43 clears fail_count/signature, resp_valid at cycle 47.
- Settle sweep: SETTLE_CYC=4, NUM_VEC=1 -> dut_in changes at cycle 3, capture at cycle 7, done at cycle 8.
